global_load_unit: RTL and testbench
===================================

// Module: global_load_unit
// PURPOSE
//  Fetch/execute stage directly upstream of the global register file.
//  Owns a private PC and a private instruction memory port, separate from the thread pipeline.
//  Runs a small global program of load-immediate (LDI), NOP and HALT instructions, and drives
//  the global register file write port (glob_reg_write_en/addr/data).
//  Paced by the scheduler through step credits: it never runs ahead of the threads.
// PARAMETERS
//  DATA_WIDTH   16  immediate / global register width
//  PC_WIDTH     8   instruction memory address width
//  MAX_CREDITS  4   max scheduler steps buffered ahead of execution (>=1)
// PORTS
//  clk                 in   1            system clock, rising edge
//  reset               in   1            asynchronous, active-low reset
//  start               in   1            pulse: begin program at PC 0 (honoured in IDLE/HALTED only)
//  step_valid          in   1            scheduler: threads advanced one instruction
//  step_ready          out  1            credit slot free; step accepted when valid&ready
//  imem_req            out  1            instruction fetch request, held until ack
//  imem_addr           out  PC_WIDTH     fetch address (= pc while imem_req)
//  imem_ack            in   1            memory response valid; imem_data sampled this cycle
//  imem_data           in   DATA_WIDTH+8 instr: [W+7:W+4] opcode, [W+3:W] dest, [W-1:0] imm
//  glob_reg_write_en   out  1            one-cycle write strobe to global register file
//  glob_reg_write_addr out  4            destination global register
//  glob_reg_write_data out  DATA_WIDTH   immediate value
//  pc                  out  PC_WIDTH     address of next instruction to fetch
//  busy                out  1            high in FETCH or EXEC
//  done                out  1            high in HALTED
//  err                 out  1            sticky: undefined opcode seen since last start
// BEHAVIOUR
//  Reset (async, reset==0)
//   - state=IDLE; pc=0; credits=0; err=0; all outputs 0 except step_ready=1.
//   - Asserting reset mid-fetch drops imem_req immediately; a late imem_ack is ignored.
//  Opcodes
//   - 4'h1 LDI: write imm to dest.
//   - 4'h0 NOP.
//   - 4'hF HALT.
//   - Anything else: executes as NOP and sets err.
//  Credit counter (0..MAX_CREDITS)
//   - step_ready = (credits < MAX_CREDITS).
//   - +1 on accepted step; -1 on each fetch ack; both in one cycle -> unchanged.
//   - Steps are accepted in every state, including IDLE and HALTED.
//  FSM
//   - IDLE: start -> FETCH.
//   - FETCH: imem_req = (credits>0); imem_addr=pc. On imem_req&imem_ack: latch instr,
//     pc<=pc+1, credits-1, -> EXEC. imem_ack while imem_req=0 is ignored.
//   - EXEC, LDI: glob_reg_write_en=1 for exactly this cycle, addr/data from the latched instr.
//   - EXEC next state:
//     - HALT -> HALTED.
//     - Instruction was fetched from address 2^PC_WIDTH-1 (pc wrapped to 0) -> HALTED.
//     - Otherwise -> FETCH.
//   - HALTED: done=1; pc holds. start -> pc=0, err=0, credits kept, -> FETCH.
//   - start in FETCH/EXEC: ignored.
//  Timing
//   - Minimum 2 cycles per instruction: ack in cycle N, write strobe in cycle N+1.
//   - glob_reg_write_addr/data are 0 whenever glob_reg_write_en=0.
//  Pacing: exactly one instruction is fetched per accepted step; no fetch with 0 credits.
// TESTING
//  1. Reset: reset=0 mid-FETCH with imem_req=1 -> imem_req=0 same cycle; pc=0, done=0, step_ready=1.
//  2. Mem {LDI r3,#0x1234; LDI r15,#0xFFFF; HALT}, 3 steps, ack same cycle
//     -> writes (3,0x1234), (15,0xFFFF) on cycles 2 and 4 after start; done=1, pc=3.
//  3. No steps after start -> imem_req stays 0 for 20 cycles.
//     One step -> exactly one fetch at addr 0.
//  4. Credits: 5 steps back-to-back with MAX_CREDITS=4 -> step_ready=0 after the 4th;
//     5th held until a fetch frees a slot.
//     Simultaneous step accept and ack -> count unchanged.
//  5. imem_ack delayed 3 cycles -> imem_req/imem_addr stable throughout; single write strobe.
//     Opcode 4'h7 -> no write, err=1; err stays set until next start.
//  6. PC_WIDTH=2, mem all NOP -> 4 fetches (addrs 0..3), then HALTED with pc=0.
//     start again -> restarts at addr 0.

Source files
------------

// File: rtl/global_load_unit.sv
// global_load_unit: fetch/execute stage feeding the global register file.
// Runs a private program of LDI / NOP / HALT from its own instruction port,
// one instruction per scheduler step credit, and emits a one-cycle write
// strobe for each LDI.
module global_load_unit #(
    parameter int DATA_WIDTH  = 16,
    parameter int PC_WIDTH    = 8,
    parameter int MAX_CREDITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  step_valid,
    output logic                  step_ready,
    output logic                  imem_req,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic                  imem_ack,
    input  logic [DATA_WIDTH+7:0] imem_data,
    output logic                  glob_reg_write_en,
    output logic [3:0]            glob_reg_write_addr,
    output logic [DATA_WIDTH-1:0] glob_reg_write_data,
    output logic [PC_WIDTH-1:0]   pc,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int CW = $clog2(MAX_CREDITS + 1);
    localparam logic [CW-1:0] CREDIT_MAX = CW'(MAX_CREDITS);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_EXEC   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t                state_reg, state_next;
    logic [PC_WIDTH-1:0]   pc_reg, pc_next;
    logic [CW-1:0]         credits_reg, credits_next;
    logic [DATA_WIDTH+7:0] instr_reg, instr_next;
    logic                  wrap_reg, wrap_next;
    logic                  err_reg, err_next;

    logic [3:0]            opcode;
    logic                  accept;
    logic                  fetch_fire;

    assign opcode = instr_reg[DATA_WIDTH+7:DATA_WIDTH+4];

    // State register; async reset also drops imem_req at once since it is decoded from state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= S_IDLE;
            pc_reg      <= '0;
            credits_reg <= '0;
            instr_reg   <= '0;
            wrap_reg    <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            credits_reg <= credits_next;
            instr_reg   <= instr_next;
            wrap_reg    <= wrap_next;
            err_reg     <= err_next;
        end
    end

    // Next-state, credit accounting and output decode.
    always_comb begin
        state_next          = state_reg;
        pc_next             = pc_reg;
        credits_next        = credits_reg;
        instr_next          = instr_reg;
        wrap_next           = wrap_reg;
        err_next            = err_reg;
        glob_reg_write_en   = 1'b0;
        glob_reg_write_addr = '0;
        glob_reg_write_data = '0;

        step_ready = (credits_reg < CREDIT_MAX);
        accept     = step_valid && step_ready;
        // A fetch is only ever requested against a banked credit.
        imem_req   = (state_reg == S_FETCH) && (credits_reg != '0);
        imem_addr  = imem_req ? pc_reg : '0;
        fetch_fire = imem_req && imem_ack;

        // Step in and fetch out in the same cycle cancel each other.
        if (accept && !fetch_fire) begin
            credits_next = credits_reg + 1'b1;
        end else if (fetch_fire && !accept) begin
            credits_next = credits_reg - 1'b1;
        end

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    pc_next    = '0;
                    err_next   = 1'b0;
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (fetch_fire) begin
                    instr_next = imem_data;
                    pc_next    = pc_reg + 1'b1;
                    // Remember that the address space is exhausted after this one.
                    wrap_next  = (pc_reg == {PC_WIDTH{1'b1}});
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (opcode == OP_LDI) begin
                    glob_reg_write_en   = 1'b1;
                    glob_reg_write_addr = instr_reg[DATA_WIDTH+3:DATA_WIDTH];
                    glob_reg_write_data = instr_reg[DATA_WIDTH-1:0];
                end
                if (opcode != OP_LDI && opcode != OP_NOP && opcode != OP_HALT) begin
                    err_next = 1'b1;
                end
                if (opcode == OP_HALT || wrap_reg) begin
                    state_next = S_HALTED;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_HALTED: begin
                if (start) begin
                    pc_next    = '0;
                    err_next   = 1'b0;
                    state_next = S_FETCH;
                end
            end
            default: state_next = S_IDLE;
        endcase

        pc   = pc_reg;
        busy = (state_reg == S_FETCH) || (state_reg == S_EXEC);
        done = (state_reg == S_HALTED);
        err  = err_reg;
    end

endmodule

// File: tb/tb_global_load_unit.sv
// Directed bench for global_load_unit: one task per scenario, inline checks.
// A second instance with a 2-bit PC covers the address-wrap halt.
module tb_global_load_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        step_valid = 1'b0;
    logic        step_ready;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [23:0] imem_data;
    logic        glob_reg_write_en;
    logic [3:0]  glob_reg_write_addr;
    logic [15:0] glob_reg_write_data;
    logic [7:0]  pc;
    logic        busy;
    logic        done;
    logic        err;

    logic        b_start = 1'b0;
    logic        b_step_valid = 1'b0;
    logic        b_step_ready;
    logic        b_req;
    logic [1:0]  b_addr;
    logic        b_ack;
    logic [23:0] b_data;
    logic        b_we;
    logic [3:0]  b_waddr;
    logic [15:0] b_wdata;
    logic [1:0]  b_pc;
    logic        b_busy;
    logic        b_done;
    logic        b_err;

    logic [23:0] mem [0:255];
    logic        ack_en = 1'b1;
    logic        ack_force = 1'b0;
    int          ack_delay = 0;
    int          req_cnt = 0;

    logic [7:0]  fetch_log [$];
    logic [19:0] wr_log [$];
    logic [1:0]  b_fetch_log [$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    global_load_unit #(.DATA_WIDTH(16), .PC_WIDTH(8), .MAX_CREDITS(4)) dut (
        .clk(clk), .reset(reset), .start(start),
        .step_valid(step_valid), .step_ready(step_ready),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .glob_reg_write_en(glob_reg_write_en),
        .glob_reg_write_addr(glob_reg_write_addr),
        .glob_reg_write_data(glob_reg_write_data),
        .pc(pc), .busy(busy), .done(done), .err(err)
    );

    global_load_unit #(.DATA_WIDTH(16), .PC_WIDTH(2), .MAX_CREDITS(4)) dut2 (
        .clk(clk), .reset(reset), .start(b_start),
        .step_valid(b_step_valid), .step_ready(b_step_ready),
        .imem_req(b_req), .imem_addr(b_addr),
        .imem_ack(b_ack), .imem_data(b_data),
        .glob_reg_write_en(b_we),
        .glob_reg_write_addr(b_waddr),
        .glob_reg_write_data(b_wdata),
        .pc(b_pc), .busy(b_busy), .done(b_done), .err(b_err)
    );

    // Memory model: ack after ack_delay waiting cycles; ack_force injects stray acks.
    always_comb begin
        imem_ack  = ack_force || (ack_en && imem_req && (req_cnt >= ack_delay));
        imem_data = mem[imem_addr];
    end

    // Second instance: all-NOP memory answering in the request cycle.
    assign b_ack  = b_req;
    assign b_data = 24'h000000;

    // Count consecutive cycles a request has waited.
    always @(posedge clk) begin
        if (imem_req && !imem_ack) req_cnt <= req_cnt + 1;
        else                       req_cnt <= 0;
    end

    // Transaction monitor: one line per fetch or register write.
    always @(posedge clk) begin
        if (imem_req && imem_ack) begin
            fetch_log.push_back(imem_addr);
            $display("[%0t] fetch addr=%0d data=%06h", $time, imem_addr, imem_data);
        end
        if (glob_reg_write_en) begin
            wr_log.push_back({glob_reg_write_addr, glob_reg_write_data});
            $display("[%0t] write r%0d=%04h", $time, glob_reg_write_addr, glob_reg_write_data);
        end
        if (b_req && b_ack) begin
            b_fetch_log.push_back(b_addr);
            $display("[%0t] dut2 fetch addr=%0d", $time, b_addr);
        end
    end

    function automatic logic [23:0] enc(input logic [3:0] op, input logic [3:0] d,
                                        input logic [15:0] imm);
        return {op, d, imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        checks++; if (step_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", step_ready); end
        checks++; if ({pc, imem_addr} !== 16'h0) begin errors++; $display("FAIL reset_pc_addr got=%h exp=0", {pc, imem_addr}); end
        checks++; if ({busy, done, err, glob_reg_write_en} !== 4'b0) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {busy, done, err, glob_reg_write_en}); end
        checks++; if ({glob_reg_write_addr, glob_reg_write_data} !== 20'h0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", {glob_reg_write_addr, glob_reg_write_data}); end
        reset = 1'b1;
        tick();
        // Park in FETCH with one credit and no response.
        ack_en = 1'b0;
        step_valid = 1'b1; tick(); step_valid = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL pre_reset_req got=%b exp=1", imem_req); end
        #3 reset = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL midreset_req got=%b exp=0", imem_req); end
        checks++; if (pc !== 8'd0 || done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midreset_state pc=%0d done=%b busy=%b exp 0/0/0", pc, done, busy); end
        checks++; if (step_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready got=%b exp=1", step_ready); end
        tick();
        reset = 1'b1;
        ack_en = 1'b1;
        fetch_log.delete();
        ack_force = 1'b1; tick(); tick(); ack_force = 1'b0;
        checks++; if (fetch_log.size() != 0 || pc !== 8'd0 || busy !== 1'b0) begin errors++; $display("FAIL late_ack fetches=%0d pc=%0d busy=%b exp 0/0/0", fetch_log.size(), pc, busy); end
    endtask

    task automatic test_program();
        mem[0] = enc(4'h1, 4'd3, 16'h1234);
        mem[1] = enc(4'h1, 4'd15, 16'hFFFF);
        mem[2] = enc(4'hF, 4'd0, 16'h0000);
        wr_log.delete();
        step_valid = 1'b1; repeat (3) tick(); step_valid = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 8'd0 || glob_reg_write_en !== 1'b0) begin errors++; $display("FAIL prog_c1 req=%b addr=%0d we=%b exp 1/0/0", imem_req, imem_addr, glob_reg_write_en); end
        tick();
        checks++; if ({glob_reg_write_en, glob_reg_write_addr, glob_reg_write_data} !== {1'b1, 4'd3, 16'h1234}) begin errors++; $display("FAIL prog_c2 got=%b/%0d/%h exp 1/3/1234", glob_reg_write_en, glob_reg_write_addr, glob_reg_write_data); end
        tick();
        checks++; if ({glob_reg_write_en, glob_reg_write_addr, glob_reg_write_data} !== 21'h0) begin errors++; $display("FAIL prog_c3 got=%b/%0d/%h exp 0/0/0", glob_reg_write_en, glob_reg_write_addr, glob_reg_write_data); end
        tick();
        checks++; if ({glob_reg_write_en, glob_reg_write_addr, glob_reg_write_data} !== {1'b1, 4'd15, 16'hFFFF}) begin errors++; $display("FAIL prog_c4 got=%b/%0d/%h exp 1/15/ffff", glob_reg_write_en, glob_reg_write_addr, glob_reg_write_data); end
        repeat (3) tick();
        checks++; if (done !== 1'b1 || pc !== 8'd3 || busy !== 1'b0) begin errors++; $display("FAIL prog_halt done=%b pc=%0d busy=%b exp 1/3/0", done, pc, busy); end
        checks++; if (wr_log.size() != 2) begin errors++; $display("FAIL prog_writes got=%0d exp=2", wr_log.size()); end
    endtask

    task automatic test_no_steps();
        int reqs;
        reqs = 0;
        fetch_log.delete();
        start = 1'b1; tick(); start = 1'b0;
        repeat (20) begin
            if (imem_req) reqs++;
            tick();
        end
        checks++; if (reqs != 0 || busy !== 1'b1 || pc !== 8'd0) begin errors++; $display("FAIL nostep reqs=%0d busy=%b pc=%0d exp 0/1/0", reqs, busy, pc); end
        step_valid = 1'b1; tick(); step_valid = 1'b0;
        repeat (8) tick();
        checks++; if (fetch_log.size() != 1 || fetch_log[0] !== 8'd0) begin errors++; $display("FAIL onestep fetches=%0d exp 1 at addr 0", fetch_log.size()); end
        checks++; if (pc !== 8'd1) begin errors++; $display("FAIL onestep_pc got=%0d exp=1", pc); end
    endtask

    task automatic test_credits();
        logic exp_ready [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 1; i < 16; i++) mem[i] = 24'h000000;
        fetch_log.delete();
        ack_en = 1'b0;
        step_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (step_ready !== exp_ready[i]) begin errors++; $display("FAIL credit_fill%0d ready=%b exp=%b", i, step_ready, exp_ready[i]); end
        end
        ack_en = 1'b1;
        tick();
        checks++; if (step_ready !== 1'b1 || fetch_log.size() != 1) begin errors++; $display("FAIL credit_free ready=%b fetches=%0d exp 1/1", step_ready, fetch_log.size()); end
        tick();
        checks++; if (step_ready !== 1'b0) begin errors++; $display("FAIL credit_fifth ready=%b exp=0", step_ready); end
        step_valid = 1'b0;
        tick(); tick();
        checks++; if (imem_req !== 1'b1 || imem_ack !== 1'b1 || step_ready !== 1'b1) begin errors++; $display("FAIL credit_pre_sim req=%b ack=%b ready=%b exp 1/1/1", imem_req, imem_ack, step_ready); end
        step_valid = 1'b1; tick(); step_valid = 1'b0;
        checks++; if (step_ready !== 1'b1) begin errors++; $display("FAIL credit_sim ready=%b exp=1", step_ready); end
        repeat (20) tick();
        checks++; if (fetch_log.size() != 6 || pc !== 8'd7) begin errors++; $display("FAIL credit_total fetches=%0d pc=%0d exp 6/7", fetch_log.size(), pc); end
        checks++; if (imem_req !== 1'b0 || step_ready !== 1'b1) begin errors++; $display("FAIL credit_drained req=%b ready=%b exp 0/1", imem_req, step_ready); end
    endtask

    task automatic test_delayed_ack();
        mem[7]  = enc(4'h1, 4'd5, 16'hABCD);
        mem[8]  = enc(4'h7, 4'd2, 16'h5555);
        mem[9]  = 24'h000000;
        mem[10] = enc(4'hF, 4'd0, 16'h0000);
        wr_log.delete();
        ack_delay = 3;
        step_valid = 1'b1; tick(); step_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (imem_req !== 1'b1 || imem_addr !== 8'd7 || imem_ack !== 1'b0 || glob_reg_write_en !== 1'b0) begin errors++; $display("FAIL wait%0d req=%b addr=%0d ack=%b we=%b exp 1/7/0/0", i, imem_req, imem_addr, imem_ack, glob_reg_write_en); end
            tick();
        end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 8'd7 || imem_ack !== 1'b1) begin errors++; $display("FAIL wait_ack req=%b addr=%0d ack=%b exp 1/7/1", imem_req, imem_addr, imem_ack); end
        tick();
        checks++; if ({glob_reg_write_en, glob_reg_write_addr, glob_reg_write_data} !== {1'b1, 4'd5, 16'hABCD}) begin errors++; $display("FAIL delayed_write got=%b/%0d/%h exp 1/5/abcd", glob_reg_write_en, glob_reg_write_addr, glob_reg_write_data); end
        tick();
        checks++; if (glob_reg_write_en !== 1'b0 || wr_log.size() != 1) begin errors++; $display("FAIL delayed_single we=%b writes=%0d exp 0/1", glob_reg_write_en, wr_log.size()); end
        ack_delay = 0;
        step_valid = 1'b1; tick(); step_valid = 1'b0;
        repeat (4) tick();
        checks++; if (err !== 1'b1 || wr_log.size() != 1) begin errors++; $display("FAIL badop err=%b writes=%0d exp 1/1", err, wr_log.size()); end
        step_valid = 1'b1; tick(); step_valid = 1'b0;
        repeat (4) tick();
        step_valid = 1'b1; tick(); step_valid = 1'b0;
        repeat (4) tick();
        checks++; if (err !== 1'b1 || done !== 1'b1 || pc !== 8'd11) begin errors++; $display("FAIL err_sticky err=%b done=%b pc=%0d exp 1/1/11", err, done, pc); end
        start = 1'b1; tick(); start = 1'b0;
        checks++; if (err !== 1'b0 || pc !== 8'd0 || busy !== 1'b1) begin errors++; $display("FAIL err_clear err=%b pc=%0d busy=%b exp 0/0/1", err, pc, busy); end
    endtask

    task automatic test_wrap();
        logic [1:0] a;
        b_fetch_log.delete();
        b_step_valid = 1'b1; repeat (4) tick(); b_step_valid = 1'b0;
        checks++; if (b_step_ready !== 1'b0) begin errors++; $display("FAIL wrap_full ready=%b exp=0", b_step_ready); end
        b_start = 1'b1; tick(); b_start = 1'b0;
        repeat (12) tick();
        checks++; if (b_done !== 1'b1 || b_pc !== 2'd0) begin errors++; $display("FAIL wrap_halt done=%b pc=%0d exp 1/0", b_done, b_pc); end
        checks++; if (b_fetch_log.size() != 4) begin errors++; $display("FAIL wrap_count got=%0d exp=4", b_fetch_log.size()); end
        for (int i = 0; i < 4; i++) begin
            a = 2'(i);
            checks++; if (b_fetch_log.size() <= i || b_fetch_log[i] !== a) begin errors++; $display("FAIL wrap_addr%0d exp=%0d", i, a); end
        end
        b_fetch_log.delete();
        b_step_valid = 1'b1; tick(); b_step_valid = 1'b0;
        b_start = 1'b1; tick(); b_start = 1'b0;
        repeat (4) tick();
        checks++; if (b_fetch_log.size() != 1 || b_fetch_log[0] !== 2'd0 || b_busy !== 1'b1) begin errors++; $display("FAIL wrap_restart fetches=%0d busy=%b exp 1 at addr 0 / 1", b_fetch_log.size(), b_busy); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 24'h000000;
        test_reset();
        test_program();
        test_no_steps();
        test_credits();
        test_delayed_ack();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
